// File: rtl/main_memory.sv
// main_memory: word-organised 32-bit memory with combinational read and synchronous serial-edit write
module main_memory #(
  parameter int    DEPTH     = 512,
  parameter string INIT_FILE = "",
  parameter bit    WRITABLE  = 1'b1
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [31:0] FETCH_ADDRESS,
  input  logic [64:0] EDIT_SERIAL,
  output logic [31:0] DATA
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [0:DEPTH-1];
  logic ready = 1'b1;
  logic we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [AW-1:0] ridx;
  logic [AW-1:0] widx;
  logic rd_ok;
  logic wr_ok;
  logic wr_en;
  logic unused_bits;
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  assign {we, waddr, wdata} = EDIT_SERIAL;
  assign ridx = FETCH_ADDRESS[AW-1:0];
  assign widx = waddr[AW-1:0];
`ifdef MAIN_MEMORY_ADDR_CHECK_EN
  assign rd_ok = {1'b0, FETCH_ADDRESS} < 33'(DEPTH);
  assign wr_ok = {1'b0, waddr} < 33'(DEPTH);
`else
  assign rd_ok = 1'b1;
  assign wr_ok = 1'b1;
`endif
  assign unused_bits = ^{FETCH_ADDRESS[31:AW], waddr[31:AW]};
  assign wr_en = WRITABLE && ENABLE && !RESET && (we == 1'b1);
  assign DATA = (ready && ENABLE && !RESET && rd_ok) ? mem[ridx] : '0;
  always_ff @(posedge CLOCK) begin
    ready <= !RESET;
    if (wr_en && wr_ok) mem[widx] <= wdata;
`ifdef MAIN_MEMORY_ADDR_CHECK_EN
    if (wr_en && !wr_ok) $display("main_memory warning: write address %0d out of range at time %0t", waddr, $time);
    if (ENABLE && !RESET && !rd_ok) $display("main_memory warning: read address %0d out of range at time %0t", FETCH_ADDRESS, $time);
`endif
  end
endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: table-driven scoreboard bench for main_memory (data and read-only instances)
module tb_main_memory;
   typedef struct {
      logic        rst;
      logic        en;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wa;
      logic [31:0] wd;
      logic [31:0] pre;
      logic [31:0] post;
   } vec_t;

`ifdef MAIN_MEMORY_ADDR_CHECK_EN
   localparam logic [31:0] WRAP3 = 32'h0;
   localparam logic [31:0] WRAP10 = 32'h0;
`else
   localparam logic [31:0] WRAP3 = 32'h77;
   localparam logic [31:0] WRAP10 = 32'h3;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en = 1'b1;
   logic [31:0] addr = '0;
   logic [64:0] edit = '0;
   logic [31:0] data;
   logic [31:0] rom_addr = '0;
   logic [64:0] rom_edit = '0;
   logic [31:0] rom_data;
   logic [31:0] sb [$];
   logic [31:0] exp_v;
   int checks = 0;
   int failures = 0;
   vec_t vecs [19];

   always #5 clk = ~clk;

   main_memory #(.DEPTH(512), .INIT_FILE(""), .WRITABLE(1'b1)) dut (
      .CLOCK(clk), .RESET(rst), .ENABLE(en),
      .FETCH_ADDRESS(addr), .EDIT_SERIAL(edit), .DATA(data)
   );

   main_memory #(.DEPTH(512), .INIT_FILE(""), .WRITABLE(1'b0)) rom (
      .CLOCK(clk), .RESET(rst), .ENABLE(en),
      .FETCH_ADDRESS(rom_addr), .EDIT_SERIAL(rom_edit), .DATA(rom_data)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, got, want);
      end
   endtask

   initial begin
      //          rst   en    addr     we    wa       wd            pre           post
      vecs[0]  = '{1'b1, 1'b1, 32'd0,   1'b0, 32'd0,   32'h0,        32'h0,        32'h0};
      vecs[1]  = '{1'b0, 1'b1, 32'd0,   1'b0, 32'd0,   32'h0,        32'h0,        32'h0};
      vecs[2]  = '{1'b0, 1'b1, 32'd4,   1'b1, 32'd4,   32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
      vecs[3]  = '{1'b0, 1'b1, 32'd4,   1'b0, 32'd4,   32'h11111111, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[4]  = '{1'b0, 1'b1, 32'd7,   1'b1, 32'd7,   32'h12345678, 32'h0,        32'h12345678};
      vecs[5]  = '{1'b1, 1'b1, 32'd7,   1'b1, 32'd7,   32'hAAAAAAAA, 32'h0,        32'h0};
      vecs[6]  = '{1'b0, 1'b1, 32'd7,   1'b0, 32'd0,   32'h0,        32'h0,        32'h12345678};
      vecs[7]  = '{1'b0, 1'b1, 32'd7,   1'b0, 32'd0,   32'h0,        32'h12345678, 32'h12345678};
      vecs[8]  = '{1'b0, 1'b1, 32'd2,   1'b1, 32'd2,   32'h99,       32'h0,        32'h99};
      vecs[9]  = '{1'b0, 1'b0, 32'd2,   1'b1, 32'd2,   32'h55,       32'h0,        32'h0};
      vecs[10] = '{1'b0, 1'b1, 32'd2,   1'b0, 32'd2,   32'h55,       32'h99,       32'h99};
      vecs[11] = '{1'b0, 1'b1, 32'd3,   1'b1, 32'd515, 32'h77,       32'h0,        WRAP3};
      vecs[12] = '{1'b0, 1'b1, 32'd515, 1'b0, 32'd0,   32'h0,        WRAP3,        WRAP3};
      vecs[13] = '{1'b0, 1'b1, 32'd10,  1'b1, 32'd10,  32'h1,        32'h0,        32'h1};
      vecs[14] = '{1'b0, 1'b1, 32'd11,  1'b1, 32'd11,  32'h2,        32'h0,        32'h2};
      vecs[15] = '{1'b0, 1'b1, 32'd10,  1'b1, 32'd10,  32'h3,        32'h1,        32'h3};
      vecs[16] = '{1'b0, 1'b1, 32'd11,  1'b0, 32'd0,   32'h0,        32'h2,        32'h2};
      vecs[17] = '{1'b0, 1'b1, 32'd522, 1'b0, 32'd0,   32'h0,        WRAP10,       WRAP10};
      vecs[18] = '{1'b0, 1'b1, 32'd3,   1'b0, 32'd0,   32'h0,        WRAP3,        WRAP3};

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         rst = vecs[i].rst;
         en = vecs[i].en;
         addr = vecs[i].addr;
         edit = {vecs[i].we, vecs[i].wa, vecs[i].wd};
         #1 check($sformatf("vec%0d_pre", i), data, vecs[i].pre);
         sb.push_back(vecs[i].post);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL vec%0d_post: scoreboard empty", i);
         end else begin
            exp_v = sb.pop_front();
            check($sformatf("vec%0d_post", i), data, exp_v);
         end
      end

      // Read-only instance: an edit word must neither write nor disturb DATA.
      @(negedge clk);
      rst = 1'b0;
      en = 1'b1;
      edit = '0;
      rom_addr = 32'd0;
      rom_edit = {1'b1, 32'd0, 32'hFFFFFFFF};
      #1 check("rom_pre", rom_data, 32'h0);
      @(posedge clk);
      #1 check("rom_edge", rom_data, 32'h0);
      @(negedge clk);
      rom_edit = '0;
      #1 check("rom_after", rom_data, 32'h0);

      // ENABLE low hides stored data combinationally, then it reappears.
      @(negedge clk);
      addr = 32'd4;
      en = 1'b0;
      #1 check("en_low_read", data, 32'h0);
      en = 1'b1;
      #1 check("en_high_read", data, 32'hDEADBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
